// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issues one RV32I integer instruction at a time to an external
//   combinational ALU and returns the captured result to a consumer.
//   Supported: ADD, SUB, ADDI, ORI, SLLI, SRLI. Anything else is answered
//   with rsp_illegal_o and never reaches the ALU.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o  request handshake (ready only when idle)
//   instr_i, rs1_data_i,
//   rs2_data_i, imm_i          instruction word and operand values
//   alu_op_o, alu_a_o, alu_b_o registered ALU controls/operands
//   alu_result_i, alu_zero_i   combinational ALU outputs
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_result_o, rsp_zero_o,
//   rsp_illegal_o              registered response payload
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic [OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic                  rsp_zero_o,
  output logic                  rsp_illegal_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(4);

  logic [1:0] state_q, state_d;

  logic [OP_WIDTH-1:0]   alu_op_q;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_zero_q, rsp_illegal_q;

  // Decode of the instruction currently on instr_i.
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                dec_legal;
  logic                dec_use_imm;
  logic [OP_WIDTH-1:0] dec_op;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_op      = OP_ADD;
    if (opcode == OPC_REG && funct3 == 3'b000) begin
      if (funct7 == 7'b0000000) begin
        dec_legal = 1'b1;
        dec_op    = OP_ADD;
      end else if (funct7 == 7'b0100000) begin
        dec_legal = 1'b1;
        dec_op    = OP_SUB;
      end
    end else if (opcode == OPC_IMM) begin
      dec_use_imm = 1'b1;
      case (funct3)
        3'b000: begin dec_legal = 1'b1;                  dec_op = OP_ADD; end
        3'b110: begin dec_legal = 1'b1;                  dec_op = OP_OR;  end
        3'b001: begin dec_legal = (funct7 == 7'b0000000); dec_op = OP_SLL; end
        3'b101: begin dec_legal = (funct7 == 7'b0000000); dec_op = OP_SRL; end
        default: ;
      endcase
    end
  end

  logic accept;
  assign accept = req_valid_i && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dec_legal ? EXEC : RESP;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Legal requests load the ALU controls; illegal ones leave them alone.
      if (accept && dec_legal) begin
        alu_op_q <= dec_op;
        alu_a_q  <= rs1_data_i;
        alu_b_q  <= dec_use_imm ? imm_i : rs2_data_i;
      end
      if (accept && !dec_legal) begin
        rsp_result_q  <= '0;
        rsp_zero_q    <= 1'b0;
        rsp_illegal_q <= 1'b1;
      end else if (state_q == EXEC) begin
        rsp_result_q  <= alu_result_i;
        rsp_zero_q    <= alu_zero_i;
        rsp_illegal_q <= 1'b0;
      end
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign alu_op_o      = alu_op_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign rsp_result_o  = rsp_result_q;
  assign rsp_zero_o    = rsp_zero_q;
  assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a behavioural ALU closes the loop, and a
// scoreboard queue holds the expected response for every issued request.
module tb_alu_issue_ctrl;

  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [31:0]   instr_i = '0;
  logic [DW-1:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0;
  logic [OW-1:0] alu_op_o;
  logic [DW-1:0] alu_a_o, alu_b_o;
  logic [DW-1:0] alu_result_i;
  logic          alu_zero_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_result_o;
  logic          rsp_zero_o, rsp_illegal_o;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .instr_i(instr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o),
    .rsp_illegal_o(rsp_illegal_o)
  );

  // Behavioural ALU driven by the DUT's registered controls.
  always_comb begin
    case (alu_op_o)
      4'd0:    alu_result_i = alu_a_o + alu_b_o;
      4'd1:    alu_result_i = alu_a_o - alu_b_o;
      4'd2:    alu_result_i = alu_a_o | alu_b_o;
      4'd3:    alu_result_i = alu_a_o << alu_b_o[4:0];
      4'd4:    alu_result_i = alu_a_o >> alu_b_o[4:0];
      default: alu_result_i = '0;
    endcase
    alu_zero_i = (alu_result_i == '0);
  end

  typedef struct {
    logic [DW-1:0] result;
    logic          zero;
    logic          illegal;
    logic [OW-1:0] op;
    logic [DW-1:0] a, b;
    int            lat;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // ALU controls the DUT should currently hold (illegal requests keep them).
  logic [OW-1:0] last_op = '0;
  logic [DW-1:0] last_a = '0, last_b = '0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] f7, input logic [4:0] lo, input logic [2:0] f3);
    return {f7, lo, 5'd2, f3, 5'd1, 7'b0010011};
  endfunction

  // Issue one request, check ALU controls, latency and payload, optionally
  // hold off the consumer for `stall` cycles while poking req_valid_i.
  task automatic run_txn(input string name, input logic [31:0] instr,
                         input logic [DW-1:0] rs1, rs2, imm,
                         input logic legal, input logic [OW-1:0] op,
                         input logic [DW-1:0] exp_b, exp_res, input int stall);
    exp_t e, got_e;
    int   cyc;
    bit   got;
    e.illegal = !legal;
    e.result  = legal ? exp_res : '0;
    e.zero    = legal && (exp_res == '0);
    e.op      = legal ? op    : last_op;
    e.a       = legal ? rs1   : last_a;
    e.b       = legal ? exp_b : last_b;
    e.lat     = legal ? 2 : 1;

    @(negedge clk);
    n_tests++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b want 1", name, req_ready_o);
    end
    req_valid_i = 1'b1; instr_i = instr;
    rs1_data_i = rs1; rs2_data_i = rs2; imm_i = imm;
    sb.push_back(e);

    cyc = 0; got = 0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      cyc++;
      if (cyc == 1) begin
        n_tests++;
        if ({alu_op_o, alu_a_o, alu_b_o} !== {e.op, e.a, e.b}) begin
          n_fail++;
          $display("FAIL %s alu_ctrl: got op=%0d a=%h b=%h want op=%0d a=%h b=%h",
                   name, alu_op_o, alu_a_o, alu_b_o, e.op, e.a, e.b);
        end
      end
      if (rsp_valid_o === 1'b1) got = 1;
    end

    got_e = sb.pop_front();
    n_tests++;
    if (!got || cyc != got_e.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, cyc, got, got_e.lat);
    end
    if (got) begin
      n_tests++;
      if ({rsp_result_o, rsp_zero_o, rsp_illegal_o} !== {got_e.result, got_e.zero, got_e.illegal}) begin
        n_fail++;
        $display("FAIL %s payload: got res=%h z=%b ill=%b want res=%h z=%b ill=%b",
                 name, rsp_result_o, rsp_zero_o, rsp_illegal_o,
                 got_e.result, got_e.zero, got_e.illegal);
      end
      for (int i = 0; i < stall; i++) begin
        req_valid_i = 1'b1;
        instr_i = enc_r(7'b0000000, 3'b000);
        @(negedge clk);
        n_tests++;
        if ({rsp_valid_o, req_ready_o, rsp_result_o, rsp_zero_o, rsp_illegal_o} !==
            {1'b1, 1'b0, got_e.result, got_e.zero, got_e.illegal}) begin
          n_fail++;
          $display("FAIL %s stall%0d: got v=%b rdy=%b res=%h z=%b ill=%b want v=1 rdy=0 res=%h z=%b ill=%b",
                   name, i, rsp_valid_o, req_ready_o, rsp_result_o, rsp_zero_o,
                   rsp_illegal_o, got_e.result, got_e.zero, got_e.illegal);
        end
      end
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    n_tests++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", name, rsp_valid_o, req_ready_o);
    end
    if (legal) begin
      last_op = op; last_a = rs1; last_b = exp_b;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_tests++;
    if ({req_ready_o, rsp_valid_o, alu_op_o, alu_a_o, alu_b_o, rsp_result_o, rsp_zero_o, rsp_illegal_o}
        !== {1'b1, 1'b0, {OW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b op=%0d a=%h b=%h res=%h z=%b ill=%b want rdy=1 rest 0",
               req_ready_o, rsp_valid_o, alu_op_o, alu_a_o, alu_b_o, rsp_result_o, rsp_zero_o, rsp_illegal_o);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_vectors();
    // Acceptance right after reset release happens inside the first txn.
    run_txn("v1_add",  32'h003100B3, 32'd5, 32'd7, 32'd0, 1'b1, 4'd0, 32'd7, 32'd12, 0);
    run_txn("v2_sub",  32'h403100B3, 32'd9, 32'd9, 32'd0, 1'b1, 4'd1, 32'd9, 32'd0, 0);
    run_txn("v3_slli", 32'h00411093, 32'd1, 32'd0, 32'd4, 1'b1, 4'd3, 32'd4, 32'd16, 0);
    run_txn("addi",    enc_i(7'h7F, 5'h1F, 3'b000), 32'd10, 32'd0, 32'hFFFF_FFFF,
            1'b1, 4'd0, 32'hFFFF_FFFF, 32'd9, 0);
    run_txn("ori",     enc_i(7'h00, 5'h0F, 3'b110), 32'hA0A0_0000, 32'd0, 32'h0000_000F,
            1'b1, 4'd2, 32'h0000_000F, 32'hA0A0_000F, 0);
    run_txn("srli",    enc_i(7'h00, 5'd3, 3'b101), 32'h8000_0000, 32'd0, 32'd3,
            1'b1, 4'd4, 32'd3, 32'h1000_0000, 0);
  endtask

  task automatic test_illegal();
    run_txn("v4_zero", 32'h0000_0000, 32'd1, 32'd2, 32'd3, 1'b0, 4'd0, 32'd0, 32'd0, 0);
    run_txn("ill_sll", enc_r(7'b0000000, 3'b001), 32'd1, 32'd2, 32'd3, 1'b0, 4'd0, 32'd0, 32'd0, 0);
    run_txn("ill_srai", enc_i(7'b0100000, 5'd2, 3'b101), 32'd1, 32'd2, 32'd3, 1'b0, 4'd0, 32'd0, 32'd0, 1);
    run_txn("ill_r_f7", enc_r(7'b0000001, 3'b000), 32'd1, 32'd2, 32'd3, 1'b0, 4'd0, 32'd0, 32'd0, 0);
  endtask

  task automatic test_backpressure();
    run_txn("v5_stall", 32'h003100B3, 32'd5, 32'd7, 32'd0, 1'b1, 4'd0, 32'd7, 32'd12, 3);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] a, b;
      a = $urandom; b = $urandom;
      case (k % 3)
        0: run_txn("rnd_add", 32'h003100B3, a, b, 32'd0, 1'b1, 4'd0, b, a + b, k % 2);
        1: run_txn("rnd_sub", 32'h403100B3, a, b, 32'd0, 1'b1, 4'd1, b, a - b, k % 2);
        default: run_txn("rnd_ori", enc_i(7'h00, 5'd0, 3'b110), a, 32'd0, b,
                         1'b1, 4'd2, b, a | b, 2);
      endcase
    end
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    req_valid_i = 1'b1; instr_i = 32'h003100B3;
    rs1_data_i = 32'd5; rs2_data_i = 32'd7;
    @(negedge clk);
    req_valid_i = 1'b0;
    n_tests++;
    if ({rsp_valid_o, req_ready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_exec_inflight: got v=%b rdy=%b want 0 0", rsp_valid_o, req_ready_o);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({req_ready_o, rsp_valid_o, alu_op_o, alu_a_o, alu_b_o, rsp_result_o, rsp_zero_o, rsp_illegal_o}
        !== {1'b1, 1'b0, {OW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_exec_outputs: got rdy=%b v=%b op=%0d a=%h b=%h res=%h want rdy=1 rest 0",
               req_ready_o, rsp_valid_o, alu_op_o, alu_a_o, alu_b_o, rsp_result_o);
    end
    last_op = '0; last_a = '0; last_b = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
        n_fail++;
        $display("FAIL rst_exec_after%0d: got v=%b rdy=%b want v=0 rdy=1", i, rsp_valid_o, req_ready_o);
      end
    end
    // Block still works after the aborted transaction.
    run_txn("post_rst", 32'h003100B3, 32'd2, 32'd3, 32'd0, 1'b1, 4'd0, 32'd3, 32'd5, 0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
